// File: rtl/adder_tree_pipe.sv
// Pipelined unsigned adder tree. There is one register level per tree level, and the
// last level can accumulate onto the previous result with a sticky overflow flag.
module adder_tree_pipe #(
    parameter int DSIZE  = 64,
    parameter int NUM_IN = 4,
    localparam int LVL   = $clog2(NUM_IN),
    localparam int OSIZE = DSIZE + LVL
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*DSIZE-1:0] in_data,
    input  logic                    in_acc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OSIZE-1:0]        out_sum,
    output logic                    out_ovf
);

    logic stall;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Level 0 is the raw input beat; levels 1..LVL-1 are registered pair sums.
    // Each level's data widens by one bit, so nothing inside the tree can overflow.
    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        localparam int N = NUM_IN >> k;
        localparam int W = DSIZE + k;

        logic [N-1:0][W-1:0] sum;
        logic                vld;
        logic                acc;

        if (k == 0) begin : g_src
            for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
                assign sum[i] = in_data[i*DSIZE +: DSIZE];
            end
            assign vld = in_valid;
            assign acc = in_acc;
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum <= '0;
                    vld <= 1'b0;
                    acc <= 1'b0;
                end else if (!stall) begin
                    vld <= g_lvl[k-1].vld;
                    acc <= g_lvl[k-1].acc;
                    for (int i = 0; i < N; i++)
                        sum[i] <= W'(g_lvl[k-1].sum[2*i]) + W'(g_lvl[k-1].sum[2*i+1]);
                end
            end
        end
    end

    logic [OSIZE-1:0] tree_sum;
    logic [OSIZE:0]   acc_sum;

    assign tree_sum = OSIZE'(g_lvl[LVL-1].sum[0]) + OSIZE'(g_lvl[LVL-1].sum[1]);
    assign acc_sum  = {1'b0, out_sum} + {1'b0, tree_sum};

    // The final level accumulates onto whatever out_sum currently holds. This applies
    // even when that result was already consumed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum   <= '0;
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            out_valid <= g_lvl[LVL-1].vld;
            if (g_lvl[LVL-1].vld) begin
                if (g_lvl[LVL-1].acc) begin
                    out_sum <= acc_sum[OSIZE-1:0];
                    out_ovf <= out_ovf | acc_sum[OSIZE];
                end else begin
                    out_sum <= tree_sum;
                    out_ovf <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed checks of adder_tree_pipe (DSIZE=8, NUM_IN=4), followed by a random
// handshake stream that is compared against an in-order accumulator model.
module tb_adder_tree_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_acc;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_sum;
    logic        out_ovf;

    int total = 0;
    int bad   = 0;

    adder_tree_pipe #(.DSIZE(8), .NUM_IN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_acc(in_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic beat(input logic [31:0] d, input logic a);
        in_valid = 1'b1;
        in_data  = d;
        in_acc   = a;
    endtask

    initial begin
        logic [9:0]  ref_sum;
        logic        ref_ovf;
        logic [10:0] s;
        logic [9:0]  tsum;
        logic [9:0]  q_sum[$];
        logic        q_ovf[$];
        int          accepted;
        int          cyc;
        logic [31:0] d;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_acc = 1'b0; out_ready = 1'b1;
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_sum", out_sum, 0);
        chk("reset_out_ovf", out_ovf, 0);
        chk("reset_in_ready", in_ready, 1);
        tick(); tick();
        rst_n = 1'b1;

        // Max operands
        beat(pack4(255, 255, 255, 255), 1'b0);
        tick();
        in_valid = 1'b0;
        chk("max_not_yet", out_valid, 0);
        tick();
        chk("max_valid", out_valid, 1);
        chk("max_sum", out_sum, 1020);
        chk("max_ovf", out_ovf, 0);
        tick();
        chk("max_consumed", out_valid, 0);

        // Back-to-back accumulate
        beat(pack4(1, 2, 3, 4), 1'b0);
        tick();
        beat(pack4(10, 10, 10, 10), 1'b1);
        tick();
        in_valid = 1'b0;
        chk("acc_first", out_sum, 10);
        tick();
        chk("acc_second_valid", out_valid, 1);
        chk("acc_second", out_sum, 50);

        // Overflow, then a fresh beat clears the flag
        beat(pack4(255, 255, 255, 255), 1'b0);
        tick();
        beat(pack4(255, 255, 255, 255), 1'b1);
        tick();
        chk("ovf_first_sum", out_sum, 1020);
        chk("ovf_first_flag", out_ovf, 0);
        beat(pack4(1, 0, 0, 0), 1'b0);
        tick();
        in_valid = 1'b0;
        chk("ovf_wrap_sum", out_sum, 1016);
        chk("ovf_set", out_ovf, 1);
        tick();
        chk("ovf_new_sum", out_sum, 1);
        chk("ovf_cleared", out_ovf, 0);
        tick();

        // Backpressure: 4 beats, out_ready low for 3 cycles
        beat(pack4(1, 1, 1, 1), 1'b0);
        tick();
        beat(pack4(2, 2, 2, 2), 1'b0);
        tick();
        chk("bp_first_valid", out_valid, 1);
        chk("bp_first_sum", out_sum, 4);
        out_ready = 1'b0;
        beat(pack4(3, 3, 3, 3), 1'b0);
        #1;
        chk("bp_in_ready_low", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_sum", out_sum, 4);
            chk("bp_hold_ready", in_ready, (i == 2) ? 0 : 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_back", in_ready, 1);
        tick();
        chk("bp_second", out_sum, 8);
        beat(pack4(4, 4, 4, 4), 1'b0);
        tick();
        in_valid = 1'b0;
        chk("bp_third", out_sum, 12);
        tick();
        chk("bp_fourth", out_sum, 16);
        chk("bp_fourth_valid", out_valid, 1);
        tick();
        chk("bp_drained", out_valid, 0);

        // Reset with two beats in flight
        beat(pack4(255, 255, 255, 255), 1'b1);
        tick();
        beat(pack4(6, 6, 6, 6), 1'b1);
        tick();
        in_valid = 1'b0;
        chk("rst_pre_sum", out_sum, 12);
        chk("rst_pre_ovf", out_ovf, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_sum", out_sum, 0);
        chk("rst_async_ovf", out_ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        tick();
        chk("rst_no_stale_1", out_valid, 0);
        tick();
        chk("rst_no_stale_2", out_valid, 0);
        beat(pack4(1, 2, 3, 4), 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst_acc_onto_zero", out_sum, 10);
        chk("rst_acc_ovf", out_ovf, 0);
        tick();

        // Random stream against an in-order model
        ref_sum  = 10'd10;
        ref_ovf  = 1'b0;
        accepted = 0;
        cyc      = 0;
        while ((accepted < 1000 || q_sum.size() != 0) && cyc < 8000) begin
            out_ready = ($urandom_range(3) != 0);
            if (accepted < 1000) begin
                d = $urandom;
                if ($urandom_range(3) == 0) d = 32'hFFFF_FFFF;
                in_valid = ($urandom_range(2) != 0);
                in_data  = d;
                in_acc   = $urandom_range(1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                chk("rand_sum", out_sum, q_sum.pop_front());
                chk("rand_ovf", out_ovf, q_ovf.pop_front());
            end
            if (in_valid && in_ready) begin
                tsum = 10'(in_data[7:0]) + 10'(in_data[15:8]) + 10'(in_data[23:16]) + 10'(in_data[31:24]);
                if (in_acc) begin
                    s       = {1'b0, ref_sum} + {1'b0, tsum};
                    ref_sum = s[9:0];
                    ref_ovf = ref_ovf | s[10];
                end else begin
                    ref_sum = tsum;
                    ref_ovf = 1'b0;
                end
                q_sum.push_back(ref_sum);
                q_ovf.push_back(ref_ovf);
                accepted++;
            end
            tick();
            cyc++;
        end
        chk("rand_all_accepted", accepted, 1000);
        chk("rand_queue_empty", q_sum.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
